// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch vs. load/store) for one shared memory port.
// Optional round-robin tie-break on simultaneous requests when MEM_ARB_RR_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_grant,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  typedef enum logic {IDLE, RD_WAIT} state_e;

  localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic              owner_q;   // 1 = data path owns the outstanding read
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              idle;
  logic              rd_done;
  logic              pick_d;

`ifdef MEM_ARB_RR_EN
  logic last_d_q;   // 1 = data was granted most recently
`endif

  always_comb begin
    idle    = (state_q == IDLE) && !reset;
    rd_done = (state_q == RD_WAIT) && (cnt_q == '0) && !reset;
`ifdef MEM_ARB_RR_EN
    pick_d  = d_req && (!if_req || !last_d_q);
`else
    pick_d  = d_req;
`endif
    d_grant   = idle && pick_d;
    if_grant  = idle && if_req && !pick_d;
    mem_en    = d_grant || if_grant;
    mem_we    = d_grant && d_we;
    mem_wdata = d_grant ? d_wdata : '0;
    if (state_q == RD_WAIT) mem_addr = addr_q;
    else if (d_grant)       mem_addr = d_addr;
    else                    mem_addr = if_addr;
    if_rvalid = rd_done && !owner_q;
    d_rvalid  = rd_done && owner_q;
    // Read data is forwarded in the rvalid cycle and held from the capture register afterwards.
    if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    d_rdata   = d_rvalid  ? mem_rdata : d_rdata_q;
    stall     = !reset && ((if_req && !if_grant) || (d_req && !d_grant) ||
                           (state_q == RD_WAIT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_d_q   <= 1'b0;
`endif
    end else begin
      if (if_rvalid) if_rdata_q <= mem_rdata;
      if (d_rvalid)  d_rdata_q  <= mem_rdata;
      case (state_q)
        IDLE: begin
          if (mem_en) begin
            owner_q <= d_grant;
            addr_q  <= mem_addr;
`ifdef MEM_ARB_RR_EN
            last_d_q <= d_grant;
`endif
            if (!mem_we) begin
              state_q <= RD_WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        RD_WAIT: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - 3'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_grant, if_rvalid, d_grant, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_en, mem_we, stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
  );

  function automatic logic [31:0] init_val(input int unsigned i);
    if (i == 16) return 32'h2108000A;
    return 32'h5A000000 + i * 32'h00010001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [7:0] w;
    w = 8'($urandom_range(0, 255));
    return {22'd0, w, 2'b00};
  endfunction

  // Memory environment: synchronous, read data appears LAT cycles after the sampling edge.
  logic [31:0] mem [256];
  logic [31:0] rd_pipe [LAT];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int unsigned i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[9:2]] : $urandom;
    for (int unsigned i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Transaction-level reference: port free from a given cycle, at most one pending read.
  logic [31:0] ref_mem [256];
  bit          ref_init = 1'b0;
  int unsigned free_at  = 0;
  bit          pend_v   = 1'b0;
  bit          pend_d;
  int unsigned pend_cyc;
  logic [31:0] pend_data, rd_addr;
  logic [31:0] e_ifrd = '0, e_drd = '0;
  bit          last_d = 1'b0;
  bit          prev_rst = 1'b0;

  always @(negedge clk) begin : model
    logic        e_ig, e_dg, e_iv, e_dv, busy;
    logic [31:0] e_addr;
    if (!ref_init) begin
      for (int unsigned i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      ref_init = 1'b1;
    end
    if (reset) begin
      chk("rst_if_grant", if_grant, 0);
      chk("rst_d_grant", d_grant, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_stall", stall, 0);
      if (prev_rst) begin
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
      end
      pend_v  = 1'b0;
      free_at = cyc + 1;
      last_d  = 1'b0;
      e_ifrd  = '0;
      e_drd   = '0;
    end else begin
      e_iv = 1'b0;
      e_dv = 1'b0;
      if (pend_v && pend_cyc == cyc) begin
        if (pend_d) begin e_dv = 1'b1; e_drd  = pend_data; end
        else        begin e_iv = 1'b1; e_ifrd = pend_data; end
        pend_v = 1'b0;
      end
      busy = (cyc < free_at);
      e_ig = 1'b0;
      e_dg = 1'b0;
      if (!busy) begin
        if (d_req && if_req) begin
`ifdef MEM_ARB_RR_EN
          e_dg = !last_d;
`else
          e_dg = 1'b1;
`endif
          e_ig = !e_dg;
        end else begin
          e_dg = d_req;
          e_ig = if_req;
        end
      end
      if (e_dg || e_ig) begin
        last_d = e_dg;
        e_addr = e_dg ? d_addr : if_addr;
        if (e_dg && d_we) begin
          ref_mem[e_addr[9:2]] = d_wdata;
          free_at = cyc + 1;
        end else begin
          pend_v    = 1'b1;
          pend_d    = e_dg;
          pend_cyc  = cyc + LAT;
          pend_data = ref_mem[e_addr[9:2]];
          rd_addr   = e_addr;
          free_at   = cyc + LAT + 1;
        end
      end else begin
        e_addr = busy ? rd_addr : if_addr;
      end
      chk("if_grant", if_grant, e_ig);
      chk("d_grant", d_grant, e_dg);
      chk("if_rvalid", if_rvalid, e_iv);
      chk("d_rvalid", d_rvalid, e_dv);
      chk("mem_en", mem_en, e_ig || e_dg);
      chk("mem_we", mem_we, e_dg && d_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_dg ? d_wdata : 32'h0);
      chk("if_rdata", if_rdata, e_ifrd);
      chk("d_rdata", d_rdata, e_drd);
      chk("stall", stall, (if_req && !e_ig) || (d_req && !e_dg) || busy);
    end
    prev_rst = reset;
  end

  initial begin
    logic ed, ei, gi, gd;
    reset = 1'b1; if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset with a pending fetch: everything quiet.
    repeat (3) begin
      @(negedge clk);
      chk("lit_rst_if_grant", if_grant, 0);
      chk("lit_rst_stall", stall, 0);
      chk("lit_rst_if_rdata", if_rdata, 0);
    end
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("lit_first_if_grant", if_grant, 1);
    chk("lit_first_mem_addr", mem_addr, 32'h40);
    tick(); if_req = 1'b0;
    @(negedge clk);
    chk("lit_fetch_stall_t1", stall, 1);
    chk("lit_fetch_rvalid_t1", if_rvalid, 0);
    tick();
    @(negedge clk);
    chk("lit_fetch_rvalid_t2", if_rvalid, 1);
    chk("lit_fetch_rdata", if_rdata, 32'h2108000A);
    chk("lit_fetch_d_rvalid", d_rvalid, 0);
    chk("lit_fetch_stall_t2", stall, 1);

    // Data write with fetch held, then fetch proceeds the next cycle.
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    if_req = 1'b1; if_addr = 32'h44;
    @(negedge clk);
    chk("lit_wr_d_grant", d_grant, 1);
    chk("lit_wr_if_grant", if_grant, 0);
    chk("lit_wr_mem_we", mem_we, 1);
    chk("lit_wr_stall", stall, 1);
    tick(); d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("lit_b2b_if_grant", if_grant, 1);
    chk("lit_b2b_mem_we", mem_we, 0);
    chk("lit_b2b_mem_addr", mem_addr, 32'h44);
    tick(); if_req = 1'b0;
    @(negedge clk);
    chk("lit_b2b_rvalid_early", if_rvalid, 0);
    tick();
    @(negedge clk);
    chk("lit_b2b_rvalid", if_rvalid, 1);
    chk("lit_b2b_rdata", if_rdata, init_val(17));

    // Read back the written word.
    tick(); d_req = 1'b1; d_addr = 32'h100;
    @(negedge clk);
    chk("lit_rd_d_grant", d_grant, 1);
    tick(); d_req = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("lit_rd_d_rvalid", d_rvalid, 1);
    chk("lit_rd_d_rdata", d_rdata, 32'hDEADBEEF);

    // Reset during the read wait aborts it.
    tick(); d_req = 1'b1; d_addr = 32'h40;
    @(negedge clk);
    chk("lit_abort_grant", d_grant, 1);
    tick(); d_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("lit_abort_d_rvalid", d_rvalid, 0);
    chk("lit_abort_d_rdata", d_rdata, 0);
    chk("lit_abort_if_rdata", if_rdata, 0);
    chk("lit_abort_stall", stall, 0);
    chk("lit_abort_mem_en", mem_en, 0);
    tick();
    @(negedge clk);
    chk("lit_abort_late_rvalid", d_rvalid, 0);

    // Both requesters held with reads.
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h48; if_req = 1'b1; if_addr = 32'h4C;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      ed = (k % 3 == 0);
      ei = 1'b0;
`ifdef MEM_ARB_RR_EN
      ei = ed && ((k / 3) % 2 == 1);
      ed = ed && !ei;
`endif
      chk("lit_tie_d_grant", d_grant, ed);
      chk("lit_tie_if_grant", if_grant, ei);
      tick();
    end
    d_req = 1'b0; if_req = 1'b0;

    // Randomized traffic with occasional resets and withdrawn requests.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      gi = if_grant;
      gd = d_grant;
      tick();
      reset = ($urandom_range(0, 249) == 0);
      if (!d_req || gd || $urandom_range(0, 15) == 0) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = rand_addr();
        d_wdata = $urandom;
      end
      if (!if_req || gi || $urandom_range(0, 15) == 0) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = rand_addr();
      end
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
